// File: rtl/dmem_pkg.sv
// Shared command codes, fault causes and decode helpers for the data-memory block.
package dmem_pkg;

   localparam logic [3:0] MEM_NONE = 4'd0;
   localparam logic [3:0] MEM_LB   = 4'd1;
   localparam logic [3:0] MEM_LH   = 4'd2;
   localparam logic [3:0] MEM_LW   = 4'd3;
   localparam logic [3:0] MEM_LBU  = 4'd4;
   localparam logic [3:0] MEM_LHU  = 4'd5;
   localparam logic [3:0] MEM_SB   = 4'd6;
   localparam logic [3:0] MEM_SH   = 4'd7;
   localparam logic [3:0] MEM_SW   = 4'd8;

   localparam logic [1:0] ERR_NONE     = 2'b00;
   localparam logic [1:0] ERR_MISALIGN = 2'b01;
   localparam logic [1:0] ERR_RANGE    = 2'b10;

   typedef enum logic [1:0] {SZ_NONE, SZ_BYTE, SZ_HALF, SZ_WORD} acc_size_e;

   function automatic logic is_load(input logic [3:0] cmd);
      return (cmd >= MEM_LB) && (cmd <= MEM_LHU);
   endfunction

   function automatic logic is_store(input logic [3:0] cmd);
      return (cmd >= MEM_SB) && (cmd <= MEM_SW);
   endfunction

   function automatic acc_size_e access_size(input logic [3:0] cmd);
      case (cmd)
         MEM_LB, MEM_LBU, MEM_SB: return SZ_BYTE;
         MEM_LH, MEM_LHU, MEM_SH: return SZ_HALF;
         MEM_LW, MEM_SW:          return SZ_WORD;
         default:                 return SZ_NONE;
      endcase
   endfunction

endpackage

// File: rtl/dmem_lane_fmt.sv
// Combinational lane formatting: load extraction/extension, store byte-enables and replicated data.
// Zero latency; no flow control.
module dmem_lane_fmt
   import dmem_pkg::*;
(
   input  logic [3:0]  cmd_i,
   input  logic [1:0]  addr_lo_i,
   input  logic [31:0] rdata_i,
   input  logic [31:0] din_i,
   output logic [31:0] ld_data_o,
   output logic [3:0]  be_o,
   output logic [31:0] wdata_o
);

   logic [31:0] shifted;
   logic [7:0]  byte_sel;
   logic [15:0] half_sel;

   assign shifted  = rdata_i >> {addr_lo_i, 3'b000};
   assign byte_sel = shifted[7:0];
   assign half_sel = addr_lo_i[1] ? rdata_i[31:16] : rdata_i[15:0];

   always_comb begin
      ld_data_o = 32'd0;
      case (cmd_i)
         MEM_LB:  ld_data_o = {{24{byte_sel[7]}}, byte_sel};
         MEM_LBU: ld_data_o = {24'd0, byte_sel};
         MEM_LH:  ld_data_o = {{16{half_sel[15]}}, half_sel};
         MEM_LHU: ld_data_o = {16'd0, half_sel};
         MEM_LW:  ld_data_o = rdata_i;
         default: ld_data_o = 32'd0;
      endcase
   end

   // Store data is replicated across lanes so the byte-enables alone pick the target.
   always_comb begin
      be_o    = 4'b0000;
      wdata_o = din_i;
      case (cmd_i)
         MEM_SB: begin
            be_o    = 4'b0001 << addr_lo_i;
            wdata_o = {4{din_i[7:0]}};
         end
         MEM_SH: begin
            be_o    = addr_lo_i[1] ? 4'b1100 : 4'b0011;
            wdata_o = {2{din_i[15:0]}};
         end
         MEM_SW: be_o = 4'b1111;
         default: be_o = 4'b0000;
      endcase
   end

endmodule

// File: rtl/dmem_ctrl.sv
// Data memory with byte-lane writes, load extension and sticky first-fault capture; zero-latency reads.
// Never stalls. Optional load/store counters under DMEM_PERF_CNT_EN.
module dmem_ctrl
   import dmem_pkg::*;
#(
   parameter  int DEPTH = 1024,
   localparam int AW    = $clog2(DEPTH)
)(
   input  logic        clk,
   input  logic        rst_n,
   input  logic [3:0]  MEM_mem_cmd,
   input  logic [31:0] MEM_mem_addr,
   input  logic [31:0] MEM_mem_din,
   input  logic        err_clr,
   output logic [31:0] DM_mem_dout,
   output logic        DM_err,
   output logic [1:0]  DM_err_cause,
   output logic [31:0] DM_err_addr
`ifdef DMEM_PERF_CNT_EN
  ,output logic [31:0] DM_ld_cnt,
   output logic [31:0] DM_st_cnt
`endif
);

   logic [31:0] mem_q [DEPTH];

   logic [AW-1:0] widx;
   logic [31:0]   rdata, ld_data, wdata;
   logic [3:0]    be;
   acc_size_e     size;
   logic          ld, st, misalign, range_err, fault, we;

   logic        err_q, err_d;
   logic [1:0]  cause_q, cause_d;
   logic [31:0] eaddr_q, eaddr_d;

   assign widx  = MEM_mem_addr[AW+1:2];
   assign rdata = mem_q[widx];
   assign size  = access_size(MEM_mem_cmd);
   assign ld    = is_load(MEM_mem_cmd);
   assign st    = is_store(MEM_mem_cmd);

   assign misalign  = ((size == SZ_HALF) && MEM_mem_addr[0]) ||
                      ((size == SZ_WORD) && (MEM_mem_addr[1:0] != 2'b00));
   assign range_err = (MEM_mem_addr >> (AW + 2)) != 32'd0;
   assign fault     = (ld || st) && (misalign || range_err);
   assign we        = st && !fault;

   dmem_lane_fmt u_lane_fmt (
      .cmd_i     (MEM_mem_cmd),
      .addr_lo_i (MEM_mem_addr[1:0]),
      .rdata_i   (rdata),
      .din_i     (MEM_mem_din),
      .ld_data_o (ld_data),
      .be_o      (be),
      .wdata_o   (wdata)
   );

   assign DM_mem_dout = (ld && !fault) ? ld_data : 32'd0;

   // Gating with rst_n drops a store whose edge lands while reset is held.
   always_ff @(posedge clk) begin
      if (we && rst_n) begin
         for (int b = 0; b < 4; b++) begin
            if (be[b]) mem_q[widx][8*b +: 8] <= wdata[8*b +: 8];
         end
      end
   end

   // A clear in the same cycle as a fault re-arms capture so the new fault is kept.
   always_comb begin
      err_d   = err_q;
      cause_d = cause_q;
      eaddr_d = eaddr_q;
      if (fault && (!err_q || err_clr)) begin
         err_d   = 1'b1;
         cause_d = misalign ? ERR_MISALIGN : ERR_RANGE;
         eaddr_d = MEM_mem_addr;
      end else if (err_clr) begin
         err_d   = 1'b0;
         cause_d = ERR_NONE;
         eaddr_d = 32'd0;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         err_q   <= 1'b0;
         cause_q <= ERR_NONE;
         eaddr_q <= 32'd0;
      end else begin
         err_q   <= err_d;
         cause_q <= cause_d;
         eaddr_q <= eaddr_d;
      end
   end

   assign DM_err       = err_q;
   assign DM_err_cause = cause_q;
   assign DM_err_addr  = eaddr_q;

`ifdef DMEM_PERF_CNT_EN
   logic [31:0] ld_cnt_q, ld_cnt_d, st_cnt_q, st_cnt_d;

   assign ld_cnt_d = (ld && !fault && (ld_cnt_q != 32'hFFFF_FFFF)) ? ld_cnt_q + 32'd1 : ld_cnt_q;
   assign st_cnt_d = (we && (st_cnt_q != 32'hFFFF_FFFF)) ? st_cnt_q + 32'd1 : st_cnt_q;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         ld_cnt_q <= 32'd0;
         st_cnt_q <= 32'd0;
      end else begin
         ld_cnt_q <= ld_cnt_d;
         st_cnt_q <= st_cnt_d;
      end
   end

   assign DM_ld_cnt = ld_cnt_q;
   assign DM_st_cnt = st_cnt_q;
`endif

endmodule

// File: doc/dmem_ctrl.md
Name: dmem_ctrl

Overview:
- Data-memory block directly downstream of the processor's MEM stage.
- Consumes MEM_mem_cmd, MEM_mem_addr and MEM_mem_din, and returns DM_mem_dout in the same cycle.
- Holds a word-organised RAM with byte-lane writes, sub-word load extension, and alignment/range checking.
- Records the first fault in sticky error registers.

Parameters:
- DEPTH, 1024, number of 32-bit words; must be a power of 2.
- AW, $clog2(DEPTH), word-index width; derived, not overridden.

Ports:
- clk  in  1  system clock; all state updates on its rising edge.
- rst_n  in  1  asynchronous, active-low reset.
- MEM_mem_cmd  in  4  access command (MEM_* encoding).
- MEM_mem_addr  in  32  byte address.
- MEM_mem_din  in  32  store data, right-aligned.
- err_clr  in  1  synchronous clear of the sticky error state.
- DM_mem_dout  out  32  load result, extended to 32 bits.
- DM_err  out  1  sticky fault flag.
- DM_err_cause  out  2  01 = misaligned, 10 = out of range, 00 = none.
- DM_err_addr  out  32  byte address of the first fault.

Behaviour:
- Clock and reset: one clock, clk. Reset rst_n is asynchronous and active-low.
- Reset values: DM_err=0, DM_err_cause=00, DM_err_addr=0, counters=0. RAM contents are not reset.
- Commands: NONE=0, LB=1, LH=2, LW=3, LBU=4, LHU=5, SB=6, SH=7, SW=8. Codes 9-15 behave as NONE and never fault.
- Read path: combinational, zero latency. DM_mem_dout is valid in the same cycle as the command.
  - Selected word is ram[addr[AW+1:2]].
  - LB/LBU select byte lane addr[1:0]; LH/LHU select half addr[1].
  - LB/LH sign-extend; LBU/LHU zero-extend.
  - DM_mem_dout=0 for NONE, stores, and any faulting access.
- Write path: on the rising clk edge, for an SB/SH/SW that does not fault.
  - SB writes lane addr[1:0] with din[7:0].
  - SH writes lanes {2a+1,2a} (a=addr[1]) with din[15:0].
  - SW writes all four lanes.
  - Other lanes are unchanged. A load in the next cycle sees the new data.
- Misaligned access: halfword with addr[0]=1, or word with addr[1:0]!=0.
- Out-of-range access: addr[31:AW+2] != 0.
- If both conditions hold, the cause is misaligned.
- A faulting access suppresses the write and returns 0.
- Fault capture:
  - On a fault while DM_err=0: DM_err←1, cause and address captured at the clk edge.
  - While DM_err=1, later faults do not update cause or address (first fault wins).
  - err_clr=1 with no new fault: all three error registers return to reset values next edge.
  - err_clr=1 in the same cycle as a new fault: the new fault is captured and the flag stays 1.
- Reset asserted mid-access: error/counter state clears immediately (asynchronous). A store whose edge coincides with reset assertion is not written.
- The block issues no stalls; every command completes in its own cycle.

Optional Feature:
- Macro: DMEM_PERF_CNT_EN.
- Defined: adds ports DM_ld_cnt (out, 32) and DM_st_cnt (out, 32).
  - Each increments by 1 per non-faulting load/store at the clk edge.
  - Each saturates at 32'hFFFF_FFFF.
  - Both reset to 0. Neither is affected by err_clr.
- Undefined: the ports and counters do not exist. All other behaviour is identical.

Decomposition:
- Shared package dmem_pkg holds:
  - the MEM_* command codes, matching the processor's MEM_NONE etc.;
  - the cause constants ERR_NONE/ERR_MISALIGN/ERR_RANGE;
  - helper functions is_load(cmd), is_store(cmd), access_size(cmd).
- One natural sub-module, dmem_lane_fmt: combinational load extraction/extension and store byte-enable/data replication, so the top holds only the RAM, fault logic and counters.

Test Plan:
- SW addr 0x10 din 0xDEADBEEF, then LW 0x10 → dout 0xDEADBEEF. Then LB 0x13 → 0xFFFFFFDE; LBU 0x13 → 0x000000DE; LH 0x12 → 0xFFFFDEAD; LHU 0x10 → 0x0000BEEF.
- SB 0x21 din 0x000000AA over SW 0x20 0x11223344, then LW 0x20 → 0x1122AA44. SH 0x22 din 0x5566 → LW 0x20 = 0x5566AA44.
- LW 0x06 → dout 0, DM_err=1, cause=01, err_addr=0x6. Then SW 0x0001_0000 (DEPTH=1024) → write suppressed, cause/addr unchanged. err_clr → DM_err=0, cause=00, err_addr=0.
- err_clr=1 together with SH 0x03 → DM_err stays 1, cause=01, err_addr=0x3. SH to an out-of-range odd address → cause=01 (misaligned has priority).
- Async reset: drop rst_n mid-cycle while DM_err=1 → DM_err=0 immediately, without waiting for a clock edge. A previously stored word is still read back intact after reset release.
- With DMEM_PERF_CNT_EN: 3 good loads, 2 good stores, 1 faulting LW → DM_ld_cnt=3, DM_st_cnt=2. Force counter to 32'hFFFF_FFFF via hierarchical deposit, then 1 load → counter stays 32'hFFFF_FFFF.
